// File: rtl/rwc_challenge_sched.sv
// rwc_challenge_sched
//   Sequences a batch of NUM_CHAL challenges through one rwc_ctrl
//   read-write-collision generator. Each challenge is evaluated REPEAT times.
//   Each of the 32 rsp_write bits is majority-voted across those evaluations.
//   The result is emitted on a valid/ready stream as one stable word, an
//   instability mask and the challenge index.
//
//   Optional feature (compile-time macro RWC_TIMEOUT_EN): a watchdog aborts the
//   batch if the generator does not answer within TIMEOUT_CYCLES cycles.
//   Without the macro there is no watchdog, RUN waits indefinitely and error
//   is tied to 0.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   start         begin a batch; only looked at in IDLE
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle pulse when the batch ends
//   gen_enable    enable for rwc_ctrl
//   cha_data      challenge data for rwc_ctrl (LFSR sequence from SEED)
//   cha_addr      challenge address for rwc_ctrl (BASE_ADDR upwards, mod 1024)
//   available     rwc_ctrl result strobe
//   rsp_write     rwc_ctrl result word
//   rsp_valid     response word valid
//   rsp_ready     consumer accepts the response
//   rsp_data      majority-voted response word
//   rsp_unstable  bits whose REPEAT votes were not unanimous
//   rsp_index     challenge index 0..NUM_CHAL-1
//   error         sticky watchdog flag
module rwc_challenge_sched #(
  parameter int          NUM_CHAL       = 16,
  parameter int          REPEAT         = 5,
  parameter int          GAP_CYCLES     = 16,
  parameter logic [9:0]  BASE_ADDR      = 10'd0,
  parameter logic [31:0] SEED           = 32'h2c77_d388,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        gen_enable,
  output logic [31:0] cha_data,
  output logic [9:0]  cha_addr,
  input  logic        available,
  input  logic [31:0] rsp_write,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_unstable,
  output logic [7:0]  rsp_index,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    EMIT
  } state_t;

  localparam logic [3:0]  REP_LAST  = 4'(REPEAT);
  localparam logic [3:0]  VOTE_HALF = 4'(REPEAT / 2);
  localparam logic [7:0]  IDX_LAST  = 8'(NUM_CHAL - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  // Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] d);
    return (d >> 1) ^ (d[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  state_t      state, state_d;
  logic [3:0]  vote [32];
  logic [3:0]  vote_d [32];
  logic [3:0]  vote_acc [32];
  logic [31:0] ones, ones_d, zeros, zeros_d;
  logic [3:0]  rep, rep_d, rep_inc;
  logic [7:0]  index, index_d;
  logic [15:0] gap_cnt, gap_cnt_d;

  logic        busy_d, done_d, gen_enable_d, rsp_valid_d;
  logic [31:0] cha_data_d, rsp_data_d, rsp_unstable_d;
  logic [9:0]  cha_addr_d;
  logic [7:0]  rsp_index_d;

`ifdef RWC_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt, to_cnt_d;
  logic        error_d;
`endif

  // Vote totals including the sample currently on rsp_write.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      vote_acc[i] = vote[i] + {3'b000, rsp_write[i]};
    end
  end

  assign rep_inc = rep + 4'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state;
    vote_d         = vote;
    ones_d         = ones;
    zeros_d        = zeros;
    rep_d          = rep;
    index_d        = index;
    gap_cnt_d      = gap_cnt;
    done_d         = 1'b0;
    gen_enable_d   = gen_enable;
    cha_data_d     = cha_data;
    cha_addr_d     = cha_addr;
    rsp_valid_d    = rsp_valid;
    rsp_data_d     = rsp_data;
    rsp_unstable_d = rsp_unstable;
    rsp_index_d    = rsp_index;
`ifdef RWC_TIMEOUT_EN
    to_cnt_d       = to_cnt;
    error_d        = error;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          gen_enable_d = 1'b1;
          index_d      = '0;
          rep_d        = '0;
          ones_d       = '0;
          zeros_d      = '0;
          for (int i = 0; i < 32; i++) vote_d[i] = '0;
          cha_addr_d   = BASE_ADDR;
          cha_data_d   = SEED;
`ifdef RWC_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end

      RUN: begin
        if (available) begin
          gen_enable_d = 1'b0;
          vote_d       = vote_acc;
          ones_d       = ones | rsp_write;
          zeros_d      = zeros | ~rsp_write;
          rep_d        = rep_inc;
          gap_cnt_d    = '0;
          if (rep_inc == REP_LAST) begin
            state_d        = EMIT;
            rsp_valid_d    = 1'b1;
            rsp_unstable_d = ones_d & zeros_d;
            rsp_index_d    = index;
            for (int i = 0; i < 32; i++) rsp_data_d[i] = (vote_acc[i] > VOTE_HALF);
          end else begin
            state_d = GAP;
          end
        end
`ifdef RWC_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          // Generator never answered: abort the whole batch.
          gen_enable_d = 1'b0;
          error_d      = 1'b1;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          to_cnt_d = to_cnt + 32'd1;
        end
`endif
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d      = RUN;
          gen_enable_d = 1'b1;
`ifdef RWC_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end else begin
          gap_cnt_d = gap_cnt + 16'd1;
        end
      end

      EMIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (index == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d    = GAP;
            index_d    = index + 8'd1;
            cha_addr_d = cha_addr + 10'd1;
            cha_data_d = lfsr_step(cha_data);
            rep_d      = '0;
            gap_cnt_d  = '0;
            ones_d     = '0;
            zeros_d    = '0;
            for (int i = 0; i < 32; i++) vote_d[i] = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before this edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      // NOTE: the vote counters are a small flop array rather than a RAM, so
      // clearing them in reset costs nothing and keeps them well defined.
      for (int i = 0; i < 32; i++) vote[i] <= '0;
      ones         <= '0;
      zeros        <= '0;
      rep          <= '0;
      index        <= '0;
      gap_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      gen_enable   <= 1'b0;
      cha_data     <= SEED;
      cha_addr     <= BASE_ADDR;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_unstable <= '0;
      rsp_index    <= '0;
    end else begin
      state        <= state_d;
      vote         <= vote_d;
      ones         <= ones_d;
      zeros        <= zeros_d;
      rep          <= rep_d;
      index        <= index_d;
      gap_cnt      <= gap_cnt_d;
      busy         <= busy_d;
      done         <= done_d;
      gen_enable   <= gen_enable_d;
      cha_data     <= cha_data_d;
      cha_addr     <= cha_addr_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_unstable <= rsp_unstable_d;
      rsp_index    <= rsp_index_d;
    end
  end

`ifdef RWC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      error  <= 1'b0;
    end else begin
      to_cnt <= to_cnt_d;
      error  <= error_d;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rwc_challenge_sched.sv
// Testbench for rwc_challenge_sched: a behavioural generator model answers each
// evaluation three cycles after gen_enable, a scoreboard queue holds the
// expected responses and a monitor compares them on every handshake.
module tb_rwc_challenge_sched;

  localparam logic [31:0] SEED  = 32'h2c77_d388;
  localparam logic [31:0] DATA1 = 32'h163B_E9C4;  // one LFSR step from SEED

  logic        clk = 1'b0;
  logic        rst, start, busy, done, gen_enable, available, rsp_valid, rsp_ready, error;
  logic [31:0] cha_data, rsp_write, rsp_data, rsp_unstable;
  logic [9:0]  cha_addr;
  logic [7:0]  rsp_index;

  rwc_challenge_sched #(
    .NUM_CHAL(2), .REPEAT(5), .GAP_CYCLES(16), .BASE_ADDR(10'd0),
    .SEED(SEED), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .gen_enable(gen_enable), .cha_data(cha_data), .cha_addr(cha_addr),
    .available(available), .rsp_write(rsp_write), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_unstable(rsp_unstable),
    .rsp_index(rsp_index), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] unstable;
    logic [7:0]  idx;
    logic [31:0] cdata;
    logic [9:0]  caddr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   model_mode = 0;   // 0 constant, 1 majority pattern, 2 silent, 3 mixed pattern
  int   rises = 0;
  int   done_count = 0;
  int   valid_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] pattern(input int mode, input int k);
    logic [31:0] mixed [5];
    mixed = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'h0000_0000};
    case (mode)
      1:       return ((k % 5) < 3) ? 32'hFFFF_FFFF : 32'h0000_0001;
      3:       return mixed[k % 5];
      default: return 32'hA5A5_0F0F;
    endcase
  endfunction

  // Generator model: available three cycles after gen_enable rises.
  initial begin
    int cnt = 0;
    int k = 0;
    available = 1'b0;
    rsp_write = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0; cnt = 0; available = 1'b0;
      end else if (gen_enable && !available && model_mode != 2) begin
        cnt++;
        if (cnt == 3) begin
          available = 1'b1;
          rsp_write = pattern(model_mode, k);
          k++;
          cnt = 0;
        end
      end else begin
        available = 1'b0;
        cnt = 0;
      end
    end
  end

  // Event counters.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_enable && !prev) rises++;
      prev = gen_enable;
      if (done) done_count++;
      if (rsp_valid) valid_count++;
    end
  end

  // Scoreboard monitor: compares on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL rsp_unexpected: got index %0d, expected no response", rsp_index);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_unstable", rsp_unstable, e.unstable);
          check("rsp_index", 32'(rsp_index), 32'(e.idx));
          check("rsp_cha_data", cha_data, e.cdata);
          check("rsp_cha_addr", 32'(cha_addr), 32'(e.caddr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic start_batch();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] u, input logic [7:0] i,
                          input logic [31:0] cd, input logic [9:0] ca);
    exp_t e;
    e.data = d; e.unstable = u; e.idx = i; e.cdata = cd; e.caddr = ca;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gen_enable"}, 32'(gen_enable), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_unstable"}, rsp_unstable, 0);
    check({tag, "_rsp_index"}, 32'(rsp_index), 0);
    check({tag, "_cha_data"}, cha_data, SEED);
    check({tag, "_cha_addr"}, 32'(cha_addr), 0);
  endtask

  // Waits for the batch to finish, then checks done count and queue drain.
  task automatic finish_batch(input string tag, input int done_base);
    int n = 0;
    while (busy && n < 3000) begin
      step(1);
      n++;
    end
    check({tag, "_batch_end"}, 32'(busy), 0);
    step(3);
    check({tag, "_done_pulses"}, 32'(done_count - done_base), 1);
    check({tag, "_rsp_all_seen"}, 32'(exp_q.size()), 0);
    check({tag, "_rsp_valid_idle"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    int n;
    int d0;
    int r0;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    rsp_ready = 1'b1;
    step(1);
    check_reset_vals("reset");
    rst = 1'b0;
    step(2);

    // Constant answers, gap length, start while busy.
    model_mode = 0;
    push_exp(32'hA5A5_0F0F, 32'h0, 8'd0, SEED, 10'd0);
    push_exp(32'hA5A5_0F0F, 32'h0, 8'd1, DATA1, 10'd1);
    d0 = done_count;
    start_batch();
    n = 0;
    while (gen_enable !== 1'b1 && n < 50) begin step(1); n++; end
    check("t1_gen_rise", 32'(gen_enable), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_run_cha_data", cha_data, SEED);
    n = 0;
    while (gen_enable === 1'b1 && n < 50) begin step(1); n++; end
    n = 0;
    while (gen_enable !== 1'b1 && n < 100) begin
      if (n == 4) start = 1'b1;
      else start = 1'b0;
      step(1);
      n++;
    end
    start = 1'b0;
    check("t1_gap_len", 32'(n), 16);
    finish_batch("t1", d0);

    // Split votes: three all-ones, two 0x1.
    do_reset();
    model_mode = 1;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd0, SEED, 10'd0);
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd1, DATA1, 10'd1);
    d0 = done_count;
    start_batch();
    finish_batch("t2", d0);

    // Mixed votes with the consumer stalled for 50 cycles.
    do_reset();
    model_mode = 3;
    rsp_ready = 1'b0;
    push_exp(32'h0000_00F0, 32'h0000_00FF, 8'd0, SEED, 10'd0);
    push_exp(32'h0000_00F0, 32'h0000_00FF, 8'd1, DATA1, 10'd1);
    d0 = done_count;
    start_batch();
    n = 0;
    while (rsp_valid !== 1'b1 && n < 500) begin step(1); n++; end
    check("t3_valid_seen", 32'(rsp_valid), 1);
    bad = 0;
    repeat (50) begin
      step(1);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_00F0 || rsp_unstable !== 32'h0000_00FF ||
          rsp_index !== 8'd0 || gen_enable !== 1'b0)
        bad++;
    end
    check("t3_hold_stable", 32'(bad), 0);
    rsp_ready = 1'b1;
    finish_batch("t3", d0);

    // Reset during the third evaluation of challenge 1, then replay.
    do_reset();
    model_mode = 0;
    push_exp(32'hA5A5_0F0F, 32'h0, 8'd0, SEED, 10'd0);
    r0 = rises;
    start_batch();
    n = 0;
    while ((rises - r0) < 8 && n < 1000) begin step(1); n++; end
    check("t4_third_eval_reached", 32'(rises - r0), 8);
    step(1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t4_midrst");
    check("t4_ch0_seen", 32'(exp_q.size()), 0);
    step(1);
    rst = 1'b0;
    step(1);
    push_exp(32'hA5A5_0F0F, 32'h0, 8'd0, SEED, 10'd0);
    push_exp(32'hA5A5_0F0F, 32'h0, 8'd1, DATA1, 10'd1);
    d0 = done_count;
    start_batch();
    check("t4_replay_cha_data", cha_data, SEED);
    finish_batch("t4", d0);

`ifdef RWC_TIMEOUT_EN
    // Silent generator: watchdog fires 64 cycles after gen_enable rises.
    do_reset();
    model_mode = 2;
    d0 = done_count;
    r0 = valid_count;
    start_batch();
    n = 0;
    while (gen_enable !== 1'b1 && n < 50) begin step(1); n++; end
    check("t5_gen_rise", 32'(gen_enable), 1);
    n = 0;
    while (error !== 1'b1 && n < 200) begin step(1); n++; end
    check("t5_timeout_cycles", 32'(n), 64);
    check("t5_gen_off", 32'(gen_enable), 0);
    check("t5_done_now", 32'(done), 1);
    step(3);
    check("t5_done_pulses", 32'(done_count - d0), 1);
    check("t5_error_sticky", 32'(error), 1);
    check("t5_idle", 32'(busy), 0);
    check("t5_no_rsp", 32'(valid_count - r0), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rwc_challenge_sched.md
Name: rwc_challenge_sched

Overview:
Sequences a batch of challenges through one rwc_ctrl read-write-collision generator instead of the fixed single challenge used at top level.
- Per challenge: fire the generator REPEAT times, majority-vote each of the 32 rsp_write bits, emit one stable response word plus an instability mask on a valid/ready stream.
- Sits between puf_top's control FSM and rwc_gen; directly drives gen_enable, cha_data and cha_addr.

Parameters:
NUM_CHAL, 16, challenges per batch (1..256)
REPEAT, 5, evaluations per challenge; must be odd, 1..15
GAP_CYCLES, 16, idle cycles with gen_enable low between evaluations (>=1)
BASE_ADDR, 10'd0, cha_addr of first challenge
SEED, 32'h2c77_d388, cha_data of first challenge; nonzero
TIMEOUT_CYCLES, 1024, watchdog limit (only with RWC_TIMEOUT_EN)

Ports:
clk  in  1  system clock (300 MHz domain)
rst  in  1  asynchronous, active-high reset
start  in  1  begin batch; sampled only in IDLE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last response handshake
gen_enable  out  1  to rwc_ctrl.gen_enable
cha_data  out  32  to rwc_ctrl.cha_data
cha_addr  out  10  to rwc_ctrl.cha_addr
available  in  1  from rwc_ctrl.available
rsp_write  in  32  from rwc_ctrl.rsp_write
rsp_valid  out  1  response word valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  majority-voted response
rsp_unstable  out  32  bit set where the REPEAT votes were not unanimous
rsp_index  out  8  challenge index 0..NUM_CHAL-1
error  out  1  sticky watchdog flag; constant 0 without the macro

Behaviour:
- All outputs registered.
- Reset values: gen_enable=0, busy=0, done=0, rsp_valid=0, error=0, rsp_data/rsp_unstable/rsp_index=0, cha_data=SEED, cha_addr=BASE_ADDR.
- Reset mid-operation returns to IDLE immediately, with outputs at reset values.
- States: IDLE, RUN, GAP, EMIT.
- IDLE:
  - start=1 at edge k: at edge k+1 enter RUN with gen_enable=1, index=0, rep=0, vote counters cleared, cha_addr=BASE_ADDR, cha_data=SEED.
- RUN:
  - gen_enable held 1 until available=1 is sampled.
  - On that edge: gen_enable<=0; per bit, vote[i] += rsp_write[i]; ones[i] |= rsp_write[i]; zeros[i] |= ~rsp_write[i]; rep++.
  - If rep reaches REPEAT, go to EMIT; otherwise go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with gen_enable=0, then go to RUN with gen_enable=1.
  - cha_data/cha_addr are constant throughout RUN and GAP of one challenge.
- EMIT:
  - On entry: rsp_valid=1, rsp_data[i] = (vote[i] > REPEAT/2), rsp_unstable[i] = ones[i] & zeros[i], rsp_index=index.
  - rsp_valid, rsp_data, rsp_unstable and rsp_index stay stable until rsp_valid & rsp_ready. rsp_ready while rsp_valid=0 is ignored.
  - On handshake, rsp_valid<=0. If index==NUM_CHAL-1: done=1 for one cycle and go to IDLE.
  - Otherwise: index++, cha_addr<=cha_addr+1 (wraps mod 1024), cha_data<=LFSR step of cha_data, clear counters/ones/zeros, go to GAP.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Step: next = (d>>1) ^ (d[0] ? 32'h8020_0003 : 0).
- Vote counters are 4 bits wide and cannot overflow given REPEAT<=15.
- available=1 outside RUN is ignored.
- start while busy is ignored.
- Simultaneous start and rst: rst wins.

Optional Feature:
RWC_TIMEOUT_EN
- Defined: a counter runs while in RUN. If TIMEOUT_CYCLES cycles elapse without available, then gen_enable<=0, error<=1 (sticky until rst), done pulses, and the FSM returns to IDLE with no further responses.
- Undefined: no counter; RUN waits indefinitely; error tied 0.

Test Plan:
- Generator model answers available 3 cycles after gen_enable with rsp_write=32'hA5A5_0F0F every time; NUM_CHAL=2, REPEAT=5, rsp_ready=1 -> two responses, rsp_data=32'hA5A5_0F0F, rsp_unstable=0, index 0 then 1; second cha_data=32'h163B_E9C4; cha_addr 0 then 1; done pulses once.
- Model returns 3x 32'hFFFF_FFFF and 2x 32'h0000_0001 -> rsp_data=32'hFFFF_FFFF, rsp_unstable=32'hFFFF_FFFE.
- Hold rsp_ready=0 for 50 cycles in EMIT -> rsp_valid/rsp_data/rsp_index unchanged; gen_enable stays 0; handshake on cycle 51 resumes sequence.
- Assert rst during the 3rd evaluation of challenge 1 -> all outputs at reset values immediately; fresh start replays challenge 0 with cha_data=SEED.
- Check gen_enable low exactly GAP_CYCLES=16 cycles between consecutive evaluations; start pulsed while busy -> no effect on index or batch length.
- With RWC_TIMEOUT_EN, TIMEOUT_CYCLES=64, model never asserts available -> error=1 and done pulse 64 cycles after gen_enable rises, gen_enable=0, no rsp_valid.
